// File: rtl/gci_node_pipe_pkg.sv
// Shared constants and state encodings for the GCI bus node.
package gci_node_pipe_pkg;

    localparam int unsigned L_PARAM_MEMSIZE_ADDR  = 0;
    localparam int unsigned L_PARAM_PRIORITY_ADDR = 4;
    localparam int unsigned L_PARAM_INTFLAG_ADDR  = 8;
    localparam int unsigned L_IRQ_W               = 24;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_MEM,
        ST_INIT_PRI,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DATAOUT
    } data_state_e;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ACK_WAIT,
        IRQ_FLAG_WAIT
    } irq_state_e;

endpackage

// File: rtl/gci_node_pipe_if.sv
// Master-side and device-side GCI signals of one node; slave = the node, master = its environment.
interface gci_node_pipe_if
    import gci_node_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                oNODE_VALID;
    logic                oNODEINFO_VALID;
    logic [7:0]          oNODEINFO_PRIORITY;
    logic [DATA_W-1:0]   oNODEINFO_MEMSIZE;

    logic                iMASTER_REQ;
    logic                oMASTER_BUSY;
    logic                iMASTER_RW;
    logic [ADDR_W-1:0]   iMASTER_ADDR;
    logic [DATA_W-1:0]   iMASTER_DATA;
    logic                oMASTER_REQ;
    logic                iMASTER_BUSY;
    logic [DATA_W-1:0]   oMASTER_DATA;
    logic                oMASTER_ERR;
    logic                oMASTER_IRQ_REQ;
    logic [L_IRQ_W-1:0]  oMASTER_IRQ_DATA;
    logic                iMASTER_IRQ_ACK;
    logic                iMASTER_IRQ_BUSY;

    logic                iDEV_VALID;
    logic                iDEV_REQ;
    logic                oDEV_BUSY;
    logic [DATA_W-1:0]   iDEV_DATA;
    logic                oDEV_REQ;
    logic                iDEV_BUSY;
    logic                oDEV_RW;
    logic [ADDR_W-1:0]   oDEV_ADDR;
    logic [DATA_W-1:0]   oDEV_DATA;
    logic                iDEV_IRQ_REQ;
    logic                oDEV_IRQ_BUSY;
    logic [L_IRQ_W-1:0]  iDEV_IRQ_DATA;
    logic                oDEV_IRQ_ACK;

    modport slave (
        output oNODE_VALID, oNODEINFO_VALID, oNODEINFO_PRIORITY, oNODEINFO_MEMSIZE,
        input  iMASTER_REQ, iMASTER_RW, iMASTER_ADDR, iMASTER_DATA, iMASTER_BUSY,
        output oMASTER_BUSY, oMASTER_REQ, oMASTER_DATA, oMASTER_ERR,
        output oMASTER_IRQ_REQ, oMASTER_IRQ_DATA,
        input  iMASTER_IRQ_ACK, iMASTER_IRQ_BUSY,
        input  iDEV_VALID, iDEV_REQ, iDEV_DATA, iDEV_BUSY, iDEV_IRQ_REQ, iDEV_IRQ_DATA,
        output oDEV_BUSY, oDEV_REQ, oDEV_RW, oDEV_ADDR, oDEV_DATA, oDEV_IRQ_BUSY, oDEV_IRQ_ACK
    );

    modport master (
        input  oNODE_VALID, oNODEINFO_VALID, oNODEINFO_PRIORITY, oNODEINFO_MEMSIZE,
        output iMASTER_REQ, iMASTER_RW, iMASTER_ADDR, iMASTER_DATA, iMASTER_BUSY,
        input  oMASTER_BUSY, oMASTER_REQ, oMASTER_DATA, oMASTER_ERR,
        input  oMASTER_IRQ_REQ, oMASTER_IRQ_DATA,
        output iMASTER_IRQ_ACK, iMASTER_IRQ_BUSY,
        output iDEV_VALID, iDEV_REQ, iDEV_DATA, iDEV_BUSY, iDEV_IRQ_REQ, iDEV_IRQ_DATA,
        input  oDEV_BUSY, oDEV_REQ, oDEV_RW, oDEV_ADDR, oDEV_DATA, oDEV_IRQ_BUSY, oDEV_IRQ_ACK
    );

endinterface

// File: rtl/gci_node_pipe_fifo.sv
// Synchronous command FIFO with flush; first word is visible on rdata while not empty.
module gci_node_pipe_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/gci_node_pipe.sv
// GCI node: device init sequence, buffered master commands with timeout, and IRQ relay.
module gci_node_pipe
    import gci_node_pipe_pkg::*;
#(
    parameter logic [7:0]  NODE_ID     = 8'h01,
    parameter logic [7:0]  RESET_CYCLE = 8'h0F,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REQ_DEPTH   = 4,
    parameter logic [15:0] TIMEOUT     = 16'd1024
) (
    input  logic            iCLOCK,
    input  logic            iRESET,
    gci_node_pipe_if.slave  bus
);
    localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;

    if (DATA_W < 8 || REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_param
        $error("gci_node_pipe %0h: DATA_W must be >=8 and REQ_DEPTH a power of 2 >=2", NODE_ID);
    end

    data_state_e         state_q, state_d;
    irq_state_e          irq_state_q, irq_state_d;
    logic [7:0]          init_cnt_q, init_cnt_d;
    logic                init_sent_q, init_sent_d;
    logic [15:0]         to_cnt_q, to_cnt_d;
    logic                info_valid_q, info_valid_d;
    logic [DATA_W-1:0]   memsize_q, memsize_d;
    logic [7:0]          priority_q, priority_d;
    logic                dev_req_q, dev_req_d, dev_rw_q, dev_rw_d;
    logic [ADDR_W-1:0]   dev_addr_q, dev_addr_d;
    logic [DATA_W-1:0]   dev_data_q, dev_data_d;
    logic                mst_req_q, mst_req_d, mst_err_q, mst_err_d;
    logic [DATA_W-1:0]   mst_data_q, mst_data_d;
    logic                irq_req_q, irq_req_d, irq_ack_q, irq_ack_d;
    logic [L_IRQ_W-1:0]  irq_data_q, irq_data_d;

    logic             master_busy, cmd_accept, flag_read;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;

    assign master_busy = !info_valid_q || fifo_full;
    assign cmd_accept  = bus.iMASTER_REQ && !master_busy;
    assign flag_read   = cmd_accept && !bus.iMASTER_RW
                         && (bus.iMASTER_ADDR == ADDR_W'(L_PARAM_INTFLAG_ADDR));

    gci_node_pipe_fifo #(.WIDTH(CMD_W), .DEPTH(REQ_DEPTH)) u_fifo (
        .clk   (iCLOCK),
        .rst   (iRESET),
        .push  (cmd_accept),
        .pop   (fifo_pop),
        .flush (!bus.iDEV_VALID),
        .wdata ({bus.iMASTER_RW, bus.iMASTER_ADDR, bus.iMASTER_DATA}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Data path FSM: init handshake, then one outstanding device transaction at a time.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_sent_d  = init_sent_q;
        to_cnt_d     = to_cnt_q;
        info_valid_d = info_valid_q;
        memsize_d    = memsize_q;
        priority_d   = priority_q;
        dev_req_d    = 1'b0;
        dev_rw_d     = dev_rw_q;
        dev_addr_d   = dev_addr_q;
        dev_data_d   = dev_data_q;
        mst_req_d    = mst_req_q;
        mst_err_d    = mst_err_q;
        mst_data_d   = mst_data_q;
        fifo_pop     = 1'b0;
        if (!bus.iDEV_VALID) begin
            state_d      = ST_INIT_WAIT;
            init_cnt_d   = '0;
            init_sent_d  = 1'b0;
            info_valid_d = 1'b0;
            mst_req_d    = 1'b0;
            mst_err_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT_WAIT: begin
                    if (init_cnt_q == RESET_CYCLE) begin
                        init_cnt_d = '0;
                        state_d    = ST_INIT_MEM;
                    end else begin
                        init_cnt_d = init_cnt_q + 8'd1;
                    end
                end
                ST_INIT_MEM, ST_INIT_PRI: begin
                    if (!init_sent_q) begin
                        if (!bus.iDEV_BUSY) begin
                            dev_req_d   = 1'b1;
                            dev_rw_d    = 1'b0;
                            dev_addr_d  = (state_q == ST_INIT_MEM) ? ADDR_W'(L_PARAM_MEMSIZE_ADDR)
                                                                   : ADDR_W'(L_PARAM_PRIORITY_ADDR);
                            dev_data_d  = '0;
                            init_sent_d = 1'b1;
                        end
                    end else if (bus.iDEV_REQ) begin
                        init_sent_d = 1'b0;
                        if (state_q == ST_INIT_MEM) begin
                            memsize_d = bus.iDEV_DATA;
                            state_d   = ST_INIT_PRI;
                        end else begin
                            priority_d   = bus.iDEV_DATA[7:0];
                            info_valid_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty && !bus.iDEV_BUSY) begin
                        fifo_pop = 1'b1;
                        {dev_rw_d, dev_addr_d, dev_data_d} = fifo_rdata;
                        if (!fifo_rdata[CMD_W-1]) dev_data_d = '0;
                        dev_req_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    // A response arriving in the timeout cycle still wins.
                    if (bus.iDEV_REQ) begin
                        mst_data_d = dev_rw_q ? '0 : bus.iDEV_DATA;
                        mst_err_d  = 1'b0;
                        mst_req_d  = 1'b1;
                        state_d    = ST_DATAOUT;
                    end else if (TIMEOUT != 16'd0 && to_cnt_q == TIMEOUT - 16'd1) begin
                        mst_data_d = '1;
                        mst_err_d  = 1'b1;
                        mst_req_d  = 1'b1;
                        state_d    = ST_DATAOUT;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
                ST_DATAOUT: begin
                    if (!bus.iMASTER_BUSY) begin
                        mst_req_d = 1'b0;
                        mst_err_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_INIT_WAIT;
            endcase
        end
    end

    // IRQ relay; frozen while the master IRQ path is busy.
    always_comb begin
        irq_state_d = irq_state_q;
        irq_req_d   = irq_req_q;
        irq_data_d  = irq_data_q;
        irq_ack_d   = 1'b0;
        if (!bus.iDEV_VALID) begin
            irq_state_d = IRQ_IDLE;
            irq_req_d   = 1'b0;
        end else if (!bus.iMASTER_IRQ_BUSY) begin
            unique case (irq_state_q)
                IRQ_IDLE: begin
                    if (bus.iDEV_IRQ_REQ) begin
                        irq_data_d  = bus.iDEV_IRQ_DATA;
                        irq_req_d   = 1'b1;
                        irq_state_d = IRQ_ACK_WAIT;
                    end
                end
                IRQ_ACK_WAIT: begin
                    if (bus.iMASTER_IRQ_ACK) begin
                        irq_req_d   = 1'b0;
                        irq_state_d = IRQ_FLAG_WAIT;
                    end
                end
                IRQ_FLAG_WAIT: begin
                    if (flag_read) begin
                        irq_ack_d   = 1'b1;
                        irq_state_d = IRQ_IDLE;
                    end
                end
                default: irq_state_d = IRQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q      <= ST_INIT_WAIT;
            irq_state_q  <= IRQ_IDLE;
            init_cnt_q   <= '0;
            init_sent_q  <= 1'b0;
            to_cnt_q     <= '0;
            info_valid_q <= 1'b0;
            memsize_q    <= '0;
            priority_q   <= '0;
            dev_req_q    <= 1'b0;
            dev_rw_q     <= 1'b0;
            dev_addr_q   <= '0;
            dev_data_q   <= '0;
            mst_req_q    <= 1'b0;
            mst_err_q    <= 1'b0;
            mst_data_q   <= '0;
            irq_req_q    <= 1'b0;
            irq_ack_q    <= 1'b0;
            irq_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            irq_state_q  <= irq_state_d;
            init_cnt_q   <= init_cnt_d;
            init_sent_q  <= init_sent_d;
            to_cnt_q     <= to_cnt_d;
            info_valid_q <= info_valid_d;
            memsize_q    <= memsize_d;
            priority_q   <= priority_d;
            dev_req_q    <= dev_req_d;
            dev_rw_q     <= dev_rw_d;
            dev_addr_q   <= dev_addr_d;
            dev_data_q   <= dev_data_d;
            mst_req_q    <= mst_req_d;
            mst_err_q    <= mst_err_d;
            mst_data_q   <= mst_data_d;
            irq_req_q    <= irq_req_d;
            irq_ack_q    <= irq_ack_d;
            irq_data_q   <= irq_data_d;
        end
    end

    assign bus.oNODE_VALID        = bus.iDEV_VALID;
    assign bus.oNODEINFO_VALID    = info_valid_q;
    assign bus.oNODEINFO_PRIORITY = priority_q;
    assign bus.oNODEINFO_MEMSIZE  = memsize_q;
    assign bus.oMASTER_BUSY       = master_busy;
    assign bus.oMASTER_REQ        = mst_req_q;
    assign bus.oMASTER_DATA       = mst_data_q;
    assign bus.oMASTER_ERR        = mst_err_q;
    assign bus.oMASTER_IRQ_REQ    = irq_req_q;
    assign bus.oMASTER_IRQ_DATA   = irq_data_q;
    assign bus.oDEV_BUSY          = 1'b0;
    assign bus.oDEV_REQ           = dev_req_q;
    assign bus.oDEV_RW            = dev_rw_q;
    assign bus.oDEV_ADDR          = dev_addr_q;
    assign bus.oDEV_DATA          = dev_data_q;
    assign bus.oDEV_IRQ_BUSY      = bus.iMASTER_IRQ_BUSY;
    assign bus.oDEV_IRQ_ACK       = irq_ack_q;

endmodule

// File: tb/tb_gci_node_pipe.sv
// Scoreboard bench for gci_node_pipe: device model plus response monitor fed by directed stimulus.
module tb_gci_node_pipe;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } dev_tx_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gci_node_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    gci_node_pipe #(
        .NODE_ID(8'h01), .RESET_CYCLE(8'h0F), .ADDR_W(32), .DATA_W(32),
        .REQ_DEPTH(4), .TIMEOUT(16'd16)
    ) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dev_req_cnt = 0;
    int irq_ack_cnt = 0;
    int last_issue_cyc = 0;
    bit dev_answer = 1'b1;
    dev_tx_t exp_dev[$];
    rsp_t    exp_rsp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] dev_reply(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0001_0000;
            32'h4:   return 32'h0000_0005;
            32'h8:   return 32'h0000_0001;
            32'h20:  return 32'hDEAD_BEEF;
            default: return 32'hA500_0000 | addr;
        endcase
    endfunction

    // Device model: checks each issued request against the expected order and answers if enabled.
    initial begin
        dev_tx_t got, want;
        bus.iDEV_REQ  = 1'b0;
        bus.iDEV_DATA = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.oDEV_REQ) begin
                got = '{rw: bus.oDEV_RW, addr: bus.oDEV_ADDR, data: bus.oDEV_DATA};
                dev_req_cnt++;
                last_issue_cyc = cyc;
                if (exp_dev.size() == 0) begin
                    fail_now("dev_unexpected_req");
                end else begin
                    want = exp_dev.pop_front();
                    chk("dev_tx", 96'(got), 96'(want));
                end
                if (dev_answer) begin
                    @(posedge clk); #1;
                    bus.iDEV_REQ  = 1'b1;
                    bus.iDEV_DATA = dev_reply(got.addr);
                    @(posedge clk); #1;
                    bus.iDEV_REQ  = 1'b0;
                    bus.iDEV_DATA = '0;
                end
            end
        end
    end

    // Response monitor: a response is consumed on a cycle with oMASTER_REQ and no back-pressure.
    always @(negedge clk) begin
        rsp_t want;
        if (!rst && bus.oMASTER_REQ && !bus.iMASTER_BUSY) begin
            if (exp_rsp.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                want = exp_rsp.pop_front();
                chk("rsp_data", 96'(bus.oMASTER_DATA), 96'(want.data));
                chk("rsp_err", 96'(bus.oMASTER_ERR), 96'(want.err));
            end
        end
    end

    always @(negedge clk) if (!rst && bus.oDEV_IRQ_ACK) irq_ack_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                            input bit exp_issue, input bit exp_resp);
        int n = 0;
        @(posedge clk); #1;
        bus.iMASTER_REQ  = 1'b1;
        bus.iMASTER_RW   = rw;
        bus.iMASTER_ADDR = addr;
        bus.iMASTER_DATA = data;
        @(negedge clk);
        while (bus.oMASTER_BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.oMASTER_BUSY) begin
            fail_now("push_timeout");
        end else begin
            if (exp_issue) exp_dev.push_back('{rw: rw, addr: addr, data: rw ? data : 32'h0});
            if (exp_resp)  exp_rsp.push_back('{data: rw ? 32'h0 : dev_reply(addr), err: 1'b0});
        end
        @(posedge clk); #1;
        bus.iMASTER_REQ = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int max);
        int n = 0;
        while ((exp_dev.size() != 0 || exp_rsp.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_dev.size() != 0 || exp_rsp.size() != 0) fail_now(name);
    endtask

    task automatic wait_info_valid(input string name);
        int n = 0;
        while (!bus.oNODEINFO_VALID && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.oNODEINFO_VALID) fail_now(name);
    endtask

    task automatic wait_master_req(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.oMASTER_REQ && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.oMASTER_REQ) fail_now(name);
    endtask

    initial begin
        int early;
        int cnt_before;
        bus.iDEV_VALID       = 1'b1;
        bus.iDEV_BUSY        = 1'b0;
        bus.iMASTER_REQ      = 1'b0;
        bus.iMASTER_RW       = 1'b0;
        bus.iMASTER_ADDR     = '0;
        bus.iMASTER_DATA     = '0;
        bus.iMASTER_BUSY     = 1'b0;
        bus.iMASTER_IRQ_ACK  = 1'b0;
        bus.iMASTER_IRQ_BUSY = 1'b0;
        bus.iDEV_IRQ_REQ     = 1'b0;
        bus.iDEV_IRQ_DATA    = '0;
        exp_dev.push_back('{rw: 1'b0, addr: 32'h0, data: 32'h0});
        exp_dev.push_back('{rw: 1'b0, addr: 32'h4, data: 32'h0});

        repeat (3) @(negedge clk);
        chk("rst_master_busy", 96'(bus.oMASTER_BUSY), 96'(1));
        chk("rst_master_req", 96'(bus.oMASTER_REQ), 96'(0));
        chk("rst_info_valid", 96'(bus.oNODEINFO_VALID), 96'(0));
        chk("rst_dev_req", 96'(bus.oDEV_REQ), 96'(0));
        chk("rst_irq_req", 96'(bus.oMASTER_IRQ_REQ), 96'(0));
        chk("node_valid", 96'(bus.oNODE_VALID), 96'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Init: no device request during the first RESET_CYCLE+1 cycles.
        early = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.oDEV_REQ) early++;
        end
        chk("init_quiet", 96'(early), 96'(0));
        wait_info_valid("init_timeout");
        chk("init_memsize", 96'(bus.oNODEINFO_MEMSIZE), 96'(32'h0001_0000));
        chk("init_priority", 96'(bus.oNODEINFO_PRIORITY), 96'(8'h05));
        chk("init_valid", 96'(bus.oNODEINFO_VALID), 96'(1));
        chk("init_busy_clear", 96'(bus.oMASTER_BUSY), 96'(0));

        // Burst of four writes against a busy device fills the FIFO.
        @(posedge clk); #1;
        bus.iDEV_BUSY = 1'b1;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b1, 32'h10 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b1, 1'b1);
        @(negedge clk);
        chk("burst_full_busy", 96'(bus.oMASTER_BUSY), 96'(1));
        chk("burst_no_issue", 96'(dev_req_cnt), 96'(2));
        @(posedge clk); #1;
        bus.iDEV_BUSY = 1'b0;
        wait_drained("burst_drain", 200);

        // Read with master back-pressure: response must hold for five cycles.
        @(posedge clk); #1;
        bus.iMASTER_BUSY = 1'b1;
        push_cmd(1'b0, 32'h20, 32'h0, 1'b1, 1'b1);
        wait_master_req("bp_no_rsp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_held", 96'(bus.oMASTER_REQ), 96'(1));
            chk("bp_data_held", 96'(bus.oMASTER_DATA), 96'(32'hDEAD_BEEF));
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.iMASTER_BUSY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_single_rsp", 96'(bus.oMASTER_REQ), 96'(0));
        chk("bp_rsp_consumed", 96'(exp_rsp.size()), 96'(0));

        // Timeout: device never answers.
        dev_answer = 1'b0;
        push_cmd(1'b0, 32'h30, 32'h0, 1'b1, 1'b0);
        exp_rsp.push_back('{data: 32'hFFFF_FFFF, err: 1'b1});
        wait_master_req("to_no_rsp");
        chk("to_latency", 96'(cyc - last_issue_cyc), 96'(17));
        chk("to_err_flag", 96'(bus.oMASTER_ERR), 96'(1));
        @(negedge clk);
        chk("to_err_clear", 96'(bus.oMASTER_ERR), 96'(0));
        chk("to_req_clear", 96'(bus.oMASTER_REQ), 96'(0));
        dev_answer = 1'b1;

        // IRQ relay and flag-read acknowledge.
        @(posedge clk); #1;
        bus.iDEV_IRQ_REQ  = 1'b1;
        bus.iDEV_IRQ_DATA = 24'hABCDEF;
        @(posedge clk); #1;
        bus.iDEV_IRQ_REQ  = 1'b0;
        bus.iDEV_IRQ_DATA = '0;
        @(negedge clk);
        chk("irq_req_set", 96'(bus.oMASTER_IRQ_REQ), 96'(1));
        chk("irq_data", 96'(bus.oMASTER_IRQ_DATA), 96'(24'hABCDEF));
        @(posedge clk); #1;
        bus.iMASTER_IRQ_ACK = 1'b1;
        @(posedge clk); #1;
        bus.iMASTER_IRQ_ACK = 1'b0;
        @(negedge clk);
        chk("irq_req_fall", 96'(bus.oMASTER_IRQ_REQ), 96'(0));
        chk("irq_no_early_ack", 96'(irq_ack_cnt), 96'(0));
        push_cmd(1'b0, 32'h8, 32'h0, 1'b1, 1'b1);
        wait_drained("irq_drain", 100);
        repeat (3) @(negedge clk);
        chk("irq_ack_single", 96'(irq_ack_cnt), 96'(1));

        // Valid drop while waiting with two commands queued: full flush and re-init.
        dev_answer = 1'b0;
        push_cmd(1'b0, 32'h40, 32'h0, 1'b1, 1'b0);
        push_cmd(1'b1, 32'h44, 32'h7, 1'b0, 1'b0);
        push_cmd(1'b1, 32'h48, 32'h8, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.iDEV_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_info_valid", 96'(bus.oNODEINFO_VALID), 96'(0));
        chk("drop_master_busy", 96'(bus.oMASTER_BUSY), 96'(1));
        chk("drop_no_rsp", 96'(bus.oMASTER_REQ), 96'(0));
        chk("drop_node_valid", 96'(bus.oNODE_VALID), 96'(0));
        cnt_before = dev_req_cnt;
        exp_dev.push_back('{rw: 1'b0, addr: 32'h0, data: 32'h0});
        exp_dev.push_back('{rw: 1'b0, addr: 32'h4, data: 32'h0});
        dev_answer = 1'b1;
        @(posedge clk); #1;
        bus.iDEV_VALID = 1'b1;
        wait_info_valid("reinit_timeout");
        repeat (20) @(negedge clk);
        chk("reinit_only_init_reqs", 96'(dev_req_cnt - cnt_before), 96'(2));
        chk("reinit_memsize", 96'(bus.oNODEINFO_MEMSIZE), 96'(32'h0001_0000));
        chk("reinit_no_rsp", 96'(bus.oMASTER_REQ), 96'(0));
        chk("dev_queue_empty", 96'(exp_dev.size()), 96'(0));
        chk("rsp_queue_empty", 96'(exp_rsp.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
